instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch/issue front end that produces the `instr_op` / `instr_field` stream consumed by `controlUnit` and `aluControlUnit`.
- Maintains a word-addressed PC.
- Reads a synchronous instruction memory with 1-cycle read latency.
- Splits each 32-bit word into opcode, funct and imm16.
- Presents them to the decode stage through a valid/ready handshake.
- Applies a branch redirect (PC+1+sext(imm16)) when the datapath reports a taken branch at handshake.

Parameters:
- ADDR_W, 8, PC / instruction-memory word-address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset (truncated to ADDR_W bits).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin fetching from current PC; sampled only in IDLE.
- imem_rd_en  output  1  instruction-memory read strobe.
- imem_addr  output  ADDR_W  instruction-memory word address (= pc).
- imem_rdata  input  32  read data, valid the cycle after imem_rd_en.
- instr_op  output  6  captured word bits [31:26].
- instr_field  output  6  captured word bits [5:0] (funct).
- instr_imm  output  16  captured word bits [15:0].
- instr_valid  output  1  captured instruction available.
- instr_ready  input  1  decode stage accepts instruction.
- branch_taken  input  1  datapath branch&zero, sampled only on handshake.
- pc  output  ADDR_W  address of the instruction being fetched/issued.
- halted  output  1  halt state indicator (stays 0 unless `HALT_DETECT_EN` is compiled in).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, pc=RESET_PC.
  - imem_rd_en=0, instr_valid=0, halted=0.
  - instr_op, instr_field and instr_imm all 0.
  - Applies from any state; an in-flight fetch is discarded.
- IDLE: start=1 -> FETCH; otherwise stay. start is ignored in all other states.
- FETCH (1 cycle): imem_rd_en=1, imem_addr=pc -> WAIT.
- WAIT (1 cycle):
  - imem_rd_en=0.
  - At the closing edge, capture imem_rdata fields into instr_op/instr_field/instr_imm and set instr_valid=1 -> ISSUE.
- ISSUE:
  - Outputs and pc are held stable while instr_valid=1 and instr_ready=0; no memory reads occur.
  - On instr_valid & instr_ready at a posedge:
    - instr_valid<=0.
    - pc <= pc+1+sext(imm16) if branch_taken, else pc+1.
    - -> FETCH.
- Latency and throughput:
  - instr_valid rises 2 cycles after the start-sampling edge.
  - After each handshake, the next instr_valid follows 2 cycles later (max 1 instruction per 3 cycles).
- Arithmetic:
  - Next-PC sum is computed at ADDR_W bits; imm16 is sign-extended, then truncated to ADDR_W bits.
  - Overflow and underflow wrap silently.
- Field outputs retain their last captured value when instr_valid=0.
- branch_taken is a don't-care outside the handshake cycle.
- No instruction is ever dropped or duplicated under any instr_ready pattern.

Optional Feature:
- Macro: `HALT_DETECT_EN`.
- Defined:
  - A captured opcode 6'b111111 is issued normally.
  - At its handshake the FSM enters HALTED: halted=1, imem_rd_en=0, pc frozen at the halt address.
  - HALTED is exited only by reset.
- Undefined:
  - No HALTED state; opcode 111111 is treated as any other instruction.
  - halted is tied 0.

Test Plan:
- Basic fetch: reset, mem[0]=32'h00221820, start pulse -> imem_rd_en=1 with imem_addr=0 next cycle; instr_valid=1 two cycles after start; instr_op=000000, instr_field=100000, instr_imm=16'h1820.
- Backpressure: mem[1]=32'h8C410004 issued with instr_ready=0 for 5 cycles -> instr_op=100011 and pc=1 stable, imem_rd_en=0 throughout; ready=1 -> next fetch at address 2.
- Branch: mem[4]=32'h1000FFFE (BEQ, imm=-2):
  - handshake with branch_taken=1 -> next imem_addr=3.
  - repeat with branch_taken=0 -> next imem_addr=5.
- Wrap: ADDR_W=8, RESET_PC=255, sequential instruction accepted -> next imem_addr=0; a branch of +1 from pc=254 -> next imem_addr=0.
- Reset mid-op: assert rst_n=0 for one edge while in WAIT -> next cycle instr_valid=0, pc=RESET_PC, imem_rd_en=0; no fetch until a new start.
- Halt:
  - With `HALT_DETECT_EN`, mem[2]=32'hFC000000 accepted -> halted=1, no further imem_rd_en, pc=2 held; start has no effect.
  - Without the macro -> the fetch at address 3 follows.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch/issue front end feeding decode over a valid/ready handshake.
//            Optional macro HALT_DETECT_EN stops issue on opcode 6'b111111.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [5:0]        instr_op,
    output logic [5:0]        instr_field,
    output logic [15:0]       instr_imm,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
`ifdef HALT_DETECT_EN
    localparam logic [5:0]        C_HALT_OP  = 6'b111111;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_ISSUE   = 3'd3
`ifdef HALT_DETECT_EN
        ,
        S_HALTED  = 3'd4
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [5:0]          r_op;
    logic [5:0]          r_field;
    logic [15:0]         r_imm;
    logic                r_valid;
    logic                w_handshake;
    logic                w_advance;
    logic [ADDR_W-1:0]   w_imm_ext;
    logic [ADDR_W-1:0]   w_pc_step;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                w_unused_bits;

    // Bits [25:16] (rs/rt) are not part of the issued fields.
    assign w_unused_bits = ^imem_rdata[25:16];

    // Sign-extend imm16 to at least ADDR_W bits, then keep the low ADDR_W.
    generate
        if (ADDR_W <= 16) begin : g_imm_trunc
            assign w_imm_ext = r_imm[ADDR_W-1:0];
        end else begin : g_imm_sext
            assign w_imm_ext = {{(ADDR_W-16){r_imm[15]}}, r_imm};
        end
    endgenerate

    assign w_handshake = (r_state == S_ISSUE) && r_valid && instr_ready;
    assign w_pc_step   = branch_taken ? w_imm_ext : '0;
    assign w_pc_next   = r_pc + ADDR_W'(1) + w_pc_step;
    // A halting handshake leaves pc on the halt address.
    assign w_advance   = w_handshake && (w_state_next == S_FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_ISSUE;
            S_ISSUE: begin
                if (w_handshake) begin
`ifdef HALT_DETECT_EN
                    w_state_next = (r_op == C_HALT_OP) ? S_HALTED : S_FETCH;
`else
                    w_state_next = S_FETCH;
`endif
                end
            end
`ifdef HALT_DETECT_EN
            S_HALTED: w_state_next = S_HALTED;
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= C_RESET_PC;
            r_op    <= '0;
            r_field <= '0;
            r_imm   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_op    <= imem_rdata[31:26];
                r_field <= imem_rdata[5:0];
                r_imm   <= imem_rdata[15:0];
                r_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_valid <= 1'b0;
            end
            if (w_advance) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign imem_rd_en  = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_op    = r_op;
    assign instr_field = r_field;
    assign instr_imm   = r_imm;
    assign instr_valid = r_valid;

`ifdef HALT_DETECT_EN
    assign halted = (r_state == S_HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Directed bench for instr_fetch_unit: main instance at RESET_PC=0, a second
// instance at RESET_PC=255 for PC wrap-around.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, ready = 1'b0, taken = 1'b0;
    logic        rd_en, valid, halted;
    logic [7:0]  addr, pc;
    logic [31:0] rdata = '0;
    logic [5:0]  op, field;
    logic [15:0] imm;

    logic        start2 = 1'b0, ready2 = 1'b0, taken2 = 1'b0;
    logic        rd_en2, valid2, halted2;
    logic [7:0]  addr2, pc2;
    logic [31:0] rdata2 = '0;
    logic [5:0]  op2, field2;
    logic [15:0] imm2;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_rd_en(rd_en), .imem_addr(addr), .imem_rdata(rdata),
        .instr_op(op), .instr_field(field), .instr_imm(imm),
        .instr_valid(valid), .instr_ready(ready), .branch_taken(taken),
        .pc(pc), .halted(halted)
    );

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(255)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_rd_en(rd_en2), .imem_addr(addr2), .imem_rdata(rdata2),
        .instr_op(op2), .instr_field(field2), .instr_imm(imm2),
        .instr_valid(valid2), .instr_ready(ready2), .branch_taken(taken2),
        .pc(pc2), .halted(halted2)
    );

    always @(posedge clk) begin
        if (rd_en)  rdata  <= mem_a[addr];
        if (rd_en2) rdata2 <= mem_b[addr2];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if ({valid, rd_en, halted} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {valid, rd_en, halted});
        end
        checks++;
        if ({op, field, imm} !== 28'h0) begin
            errors++; $display("FAIL reset_fields got %h want 0", {op, field, imm});
        end
        checks++;
        if (pc !== 8'd0 || pc2 !== 8'd255) begin
            errors++; $display("FAIL reset_pc got %0d/%0d want 0/255", pc, pc2);
        end
        tick();
        tick();
        checks++;
        if (rd_en !== 1'b0) begin
            errors++; $display("FAIL idle_no_fetch got %b want 0", rd_en);
        end
    endtask

    task automatic test_basic;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || addr !== 8'd0) begin
            errors++; $display("FAIL basic_fetch got rd=%b addr=%0d want 1/0", rd_en, addr);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL basic_wait got v=%b rd=%b want 0/0", valid, rd_en);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || op !== 6'b000000 || field !== 6'b100000 || imm !== 16'h1820) begin
            errors++; $display("FAIL basic_issue got v=%b op=%b f=%b imm=%h want 1/000000/100000/1820",
                               valid, op, field, imm);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0 || rd_en !== 1'b1 || addr !== 8'd1) begin
            errors++; $display("FAIL basic_next got v=%b rd=%b addr=%0d want 0/1/1", valid, rd_en, addr);
        end
    endtask

    task automatic test_backpressure;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || op !== 6'b100011 || imm !== 16'h0004 || pc !== 8'd1 || rd_en !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b op=%b imm=%h pc=%0d rd=%b want 1/100011/0004/1/0",
                                   i, valid, op, imm, pc, rd_en);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || addr !== 8'd2) begin
            errors++; $display("FAIL bp_next got rd=%b addr=%0d want 1/2", rd_en, addr);
        end
    endtask

    task automatic test_halt;
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || op !== 6'b111111) begin
            errors++; $display("FAIL halt_issue got v=%b op=%b want 1/111111", valid, op);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
`ifdef HALT_DETECT_EN
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (halted !== 1'b1 || rd_en !== 1'b0 || pc !== 8'd2 || valid !== 1'b0) begin
                errors++; $display("FAIL halt_hold[%0d] got h=%b rd=%b pc=%0d v=%b want 1/0/2/0",
                                   i, halted, rd_en, pc, valid);
            end
            tick();
        end
        start = 1'b0;
`else
        checks++;
        if (halted !== 1'b0 || rd_en !== 1'b1 || addr !== 8'd3) begin
            errors++; $display("FAIL nohalt_next got h=%b rd=%b addr=%0d want 0/1/3", halted, rd_en, addr);
        end
`endif
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (valid !== 1'b0 || pc !== 8'd0 || rd_en !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL midreset got v=%b pc=%0d rd=%b h=%b want 0/0/0/0", valid, pc, rd_en, halted);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rd_en !== 1'b0 || valid !== 1'b0) begin
                errors++; $display("FAIL midreset_idle[%0d] got rd=%b v=%b want 0/0", i, rd_en, valid);
            end
        end
    endtask

    task automatic test_branch;
        mem_a[0] = 32'h10000003;
        mem_a[3] = 32'h10000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        ready = 1'b1; taken = 1'b1;
        tick();
        ready = 1'b0; taken = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || addr !== 8'd4) begin
            errors++; $display("FAIL br_fwd got rd=%b addr=%0d want 1/4", rd_en, addr);
        end
        tick();
        tick();
        checks++;
        if (imm !== 16'hFFFE || pc !== 8'd4) begin
            errors++; $display("FAIL br_beq got imm=%h pc=%0d want fffe/4", imm, pc);
        end
        ready = 1'b1; taken = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (addr !== 8'd3) begin
            errors++; $display("FAIL br_taken got addr=%0d want 3", addr);
        end
        // taken held high outside the handshake must not matter
        tick();
        tick();
        taken = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (addr !== 8'd4) begin
            errors++; $display("FAIL br_dontcare got addr=%0d want 4", addr);
        end
        tick();
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (addr !== 8'd5 || rd_en !== 1'b1) begin
            errors++; $display("FAIL br_not_taken got addr=%0d rd=%b want 5/1", addr, rd_en);
        end
    endtask

    task automatic test_wrap;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checks++;
        if (rd_en2 !== 1'b1 || addr2 !== 8'd255) begin
            errors++; $display("FAIL wrap_first got rd=%b addr=%0d want 1/255", rd_en2, addr2);
        end
        tick();
        tick();
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        checks++;
        if (addr2 !== 8'd0) begin
            errors++; $display("FAIL wrap_seq got addr=%0d want 0", addr2);
        end
        tick();
        tick();
        ready2 = 1'b1; taken2 = 1'b1;
        tick();
        ready2 = 1'b0; taken2 = 1'b0;
        checks++;
        if (addr2 !== 8'd254) begin
            errors++; $display("FAIL wrap_jump got addr=%0d want 254", addr2);
        end
        tick();
        tick();
        ready2 = 1'b1; taken2 = 1'b1;
        tick();
        ready2 = 1'b0; taken2 = 1'b0;
        checks++;
        if (addr2 !== 8'd0 || rd_en2 !== 1'b1) begin
            errors++; $display("FAIL wrap_branch got addr=%0d rd=%b want 0/1", addr2, rd_en2);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[0]   = 32'h00221820;
        mem_a[1]   = 32'h8C410004;
        mem_a[2]   = 32'hFC000000;
        mem_a[4]   = 32'h1000FFFE;
        mem_b[255] = 32'h00000020;
        mem_b[0]   = 32'h100000FD;
        mem_b[254] = 32'h10000001;

        test_reset();
        test_basic();
        test_backpressure();
        test_halt();
        test_reset_mid();
        test_branch();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
